mdu_ctrl: RTL and testbench
===========================

MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: start  input  1  E-stage mult/div/mthi/mtlo issue strobe, one cycle per instruction.
REQ-004 SHALL have port: op  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO; 6,7 reserved.
REQ-005 SHALL have port: a  input  32  rs operand.
REQ-006 SHALL have port: b  input  32  rt operand.
REQ-007 SHALL have port: md_req  input  1  D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo.
REQ-008 SHALL have port: busy  output  1  unit computing.
REQ-009 SHALL have port: stall  output  1  freeze-D request to the hazard unit.
REQ-010 SHALL have port: hi  output  32  HI register.
REQ-011 SHALL have port: lo  output  32  LO register.
REQ-012 SHALL have parameters: MUL_LAT, default 5, multiply latency in cycles; DIV_LAT, default 10, divide latency in cycles.

Function
REQ-013 SHALL implement FSM IDLE/MUL/DIV with a 4-bit down-counter; busy=1 iff state!=IDLE.
REQ-014 SHALL, in IDLE with start=1 and op in 0..3, latch a, b and op at that edge, load counter with MUL_LAT (ops 0,1) or DIV_LAT (ops 2,3), and enter MUL or DIV.
REQ-015 SHALL keep busy=1 for exactly MUL_LAT or DIV_LAT cycles after the start edge, then at the last busy edge write hi/lo and return to IDLE; busy=0 in the following cycle.
REQ-016 SHALL compute from the latched operands only; a/b changes after the start edge have no effect.
REQ-017 SHALL, for MULT, produce the signed 64-bit a*b ({hi,lo}); for MULTU, the unsigned 64-bit product.
REQ-018 SHALL, for DIV, set lo=signed quotient (truncated toward zero) and hi=remainder with the dividend's sign; for DIVU, the unsigned quotient and remainder.
REQ-019 SHALL, for DIV 0x80000000 / 0xFFFFFFFF, set lo=0x80000000, hi=0.
REQ-020 SHALL, on divide with b=0, run full DIV_LAT busy and leave hi/lo unchanged.
REQ-021 SHALL, in IDLE with start=1 and op=4 (MTHI) or op=5 (MTLO), write a to hi or lo at that edge; busy stays 0.
REQ-022 SHALL ignore start while busy=1 (no state, counter, or hi/lo change), and ignore start with op 6 or 7 in any state.
REQ-023 SHALL drive stall = md_req & (busy | (start & op<=3)), combinationally.
REQ-024 SHALL drive hi and lo directly from registers (no combinational path from a/b).

Reset
REQ-025 SHALL, on reset assertion and asynchronously, set state=IDLE, counter=0, busy=0, hi=0, lo=0, and clear latched operands.
REQ-026 SHALL discard any in-flight operation on reset, with no hi/lo write; a start in the first edge after deassertion is accepted normally.

Verification
REQ-027 SHALL verify: reset, then MULT a=0xFFFFFFFE (-2), b=3 -> busy=1 for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-028 SHALL verify: MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> after 5 cycles, hi=0xFFFFFFFE, lo=0x00000001.
REQ-029 SHALL verify: DIV a=0xFFFFFFF9 (-7), b=2 -> busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/0 afterwards -> busy 10 cycles, hi/lo unchanged.
REQ-030 SHALL verify: start MULT, then on cycle 2 drive start DIV and md_req=1 -> DIV ignored, stall=1 through cycle 5, MULT result correct, stall=0 once busy=0.
REQ-031 SHALL verify: MTHI a=0x12345678 while IDLE -> hi=0x12345678 at next edge; MTLO issued while busy -> lo unchanged.
REQ-032 SHALL verify: reset asserted mid-edge on cycle 4 of a DIV -> busy, hi, lo = 0 immediately without a clock edge; no later write occurs.

Source files
------------

// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: a fixed-latency IDLE/MUL/DIV sequencer that owns HI/LO.
// Results are computed from operands captured at issue and written on the last busy edge.
module mdu_ctrl #(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        md_req,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic        uns_q;

    logic [63:0] prod;
    logic        neg_a;
    logic        neg_b;
    logic [31:0] ua;
    logic [31:0] ub;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [31:0] quo;
    logic [31:0] rem;

    // Signed division runs on magnitudes; 0x80000000 / -1 then wraps naturally to 0x80000000.
    always_comb begin
        prod  = uns_q ? ({32'd0, a_q} * {32'd0, b_q})
                      : ({{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q});
        neg_a = ~uns_q & a_q[31];
        neg_b = ~uns_q & b_q[31];
        ua    = neg_a ? (~a_q + 32'd1) : a_q;
        ub    = neg_b ? (~b_q + 32'd1) : b_q;
        uq    = (ub == 32'd0) ? 32'd0 : (ua / ub);
        ur    = (ub == 32'd0) ? 32'd0 : (ua % ub);
        quo   = (neg_a ^ neg_b) ? (~uq + 32'd1) : uq;
        rem   = neg_a ? (~ur + 32'd1) : ur;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
            busy  <= 1'b0;
            hi    <= 32'd0;
            lo    <= 32'd0;
            a_q   <= 32'd0;
            b_q   <= 32'd0;
            uns_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        case (op)
                            3'd0, 3'd1: begin
                                a_q   <= a;
                                b_q   <= b;
                                uns_q <= op[0];
                                cnt   <= 4'(MUL_LAT);
                                state <= MUL;
                                busy  <= 1'b1;
                            end
                            3'd2, 3'd3: begin
                                a_q   <= a;
                                b_q   <= b;
                                uns_q <= op[0];
                                cnt   <= 4'(DIV_LAT);
                                state <= DIV;
                                busy  <= 1'b1;
                            end
                            3'd4:    hi <= a;
                            3'd5:    lo <= a;
                            default: ;
                        endcase
                    end
                end
                MUL, DIV: begin
                    // Divide by zero still burns the full latency but leaves HI/LO alone.
                    if (cnt <= 4'd1) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        cnt   <= 4'd0;
                        if (state == MUL) begin
                            hi <= prod[63:32];
                            lo <= prod[31:0];
                        end else if (b_q != 32'd0) begin
                            hi <= rem;
                            lo <= quo;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign stall = md_req & (busy | (start & (op <= 3'd3)));

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: hand-computed HI/LO results, busy timing, stall and reset behaviour.
module tb_mdu_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        md_req;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int          total;
    int          bad;
    logic [31:0] expHi;
    logic [31:0] expLo;

    mdu_ctrl #(.MUL_LAT(5), .DIV_LAT(10)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .md_req (md_req),
        .busy   (busy),
        .stall  (stall),
        .hi     (hi),
        .lo     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic [2:0] opc, input logic [31:0] av,
                                 input logic [31:0] bv, input logic md);
        start  = st;
        op     = opc;
        a      = av;
        b      = bv;
        md_req = md;
    endtask

    // Issues one mult/div, scrambles operands after issue, optionally injects a second start
    // while busy, then checks busy length and the HI/LO outcome.
    task automatic runOp(input string tag, input logic [2:0] opc, input logic [31:0] av,
                         input logic [31:0] bv, input int lat, input logic [31:0] rh,
                         input logic [31:0] rl, input logic wr, input logic inj,
                         input logic [2:0] iop);
        applyStimulus(1'b1, opc, av, bv, 1'b0);
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd1);
            if (i == 0) applyStimulus(1'b0, opc, ~av, 32'h1, 1'b0);
            if (inj && i == 1) applyStimulus(1'b1, iop, 32'h55555555, 32'h3, 1'b1);
            if (inj && i == 2) begin
                applyStimulus(1'b0, iop, 32'h0, 32'h0, 1'b1);
                checkOutput({tag, "_hi_held"}, hi, expHi);
                checkOutput({tag, "_lo_held"}, lo, expLo);
            end
            if (inj && i >= 1) begin
                #1;
                checkOutput({tag, "_stall"}, {31'd0, stall}, 32'd1);
            end
        end
        @(negedge clk);
        if (wr) begin
            expHi = rh;
            expLo = rl;
        end
        checkOutput({tag, "_done"}, {31'd0, busy}, 32'd0);
        checkOutput({tag, "_stall_off"}, {31'd0, stall}, 32'd0);
        checkOutput({tag, "_hi"}, hi, expHi);
        checkOutput({tag, "_lo"}, lo, expLo);
        applyStimulus(1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        expHi = 32'd0;
        expLo = 32'd0;
        reset = 1'b1;
        applyStimulus(1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_hi", hi, 32'd0);
        checkOutput("rst_lo", lo, 32'd0);
        reset = 1'b0;

        runOp("mult", 3'd0, 32'hFFFFFFFE, 32'h3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b1, 1'b0, 3'd0);
        runOp("multu", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 32'hFFFFFFFE, 32'h00000001, 1'b1, 1'b0, 3'd0);
        runOp("div", 3'd2, 32'hFFFFFFF9, 32'h2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b1, 1'b0, 3'd0);
        runOp("divu_zero", 3'd3, 32'h7, 32'h0, 10, 32'h0, 32'h0, 1'b0, 1'b0, 3'd0);
        runOp("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 10, 32'h0, 32'h80000000, 1'b1, 1'b0, 3'd0);
        runOp("divu", 3'd3, 32'd100, 32'd7, 10, 32'd2, 32'd14, 1'b1, 1'b0, 3'd0);
        runOp("div_negb", 3'd2, 32'd7, 32'hFFFFFFFE, 10, 32'h1, 32'hFFFFFFFD, 1'b1, 1'b0, 3'd0);
        runOp("mult_injdiv", 3'd0, 32'h00010000, 32'hFFFF0000, 5, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b1, 3'd2);

        // Issue-cycle stall: mult/div with md_req stalls, MTHI does not.
        applyStimulus(1'b1, 3'd4, 32'h12345678, 32'h0, 1'b1);
        #1;
        checkOutput("mthi_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        checkOutput("mthi_hi", hi, 32'h12345678);
        checkOutput("mthi_lo", lo, 32'h00000000);
        checkOutput("mthi_busy", {31'd0, busy}, 32'd0);
        expHi = 32'h12345678;

        applyStimulus(1'b1, 3'd5, 32'hCAFEF00D, 32'h0, 1'b0);
        @(negedge clk);
        checkOutput("mtlo_lo", lo, 32'hCAFEF00D);
        checkOutput("mtlo_hi", hi, 32'h12345678);
        expLo = 32'hCAFEF00D;

        applyStimulus(1'b1, 3'd6, 32'hAAAAAAAA, 32'h0, 1'b0);
        @(negedge clk);
        checkOutput("rsv_busy", {31'd0, busy}, 32'd0);
        checkOutput("rsv_hi", hi, expHi);
        checkOutput("rsv_lo", lo, expLo);

        applyStimulus(1'b1, 3'd1, 32'h2, 32'h3, 1'b1);
        #1;
        checkOutput("issue_stall", {31'd0, stall}, 32'd1);
        applyStimulus(1'b0, 3'd0, 32'h0, 32'h0, 1'b0);

        runOp("mult_injmtlo", 3'd0, 32'h3, 32'h4, 5, 32'h0, 32'hC, 1'b1, 1'b1, 3'd5);

        // Asynchronous reset in the middle of a divide.
        applyStimulus(1'b1, 3'd2, 32'd100, 32'd3, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("arst_busy", {31'd0, busy}, 32'd0);
        checkOutput("arst_hi", hi, 32'd0);
        checkOutput("arst_lo", lo, 32'd0);
        expHi = 32'd0;
        expLo = 32'd0;
        @(negedge clk);
        reset = 1'b0;
        runOp("post_rst", 3'd0, 32'd5, 32'd6, 5, 32'd0, 32'd30, 1'b1, 1'b0, 3'd0);
        repeat (12) @(negedge clk);
        checkOutput("late_hi", hi, 32'd0);
        checkOutput("late_lo", lo, 32'd30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
